count_capture: RTL and testbench

Input-capture stage downstream of the free-running counter. It synchronises an asynchronous event pin and detects the selected edge. On each detected edge it timestamps the counter's current `count` value. Timestamps are buffered in a small FIFO and presented to a consumer over a valid/ready interface, with a sticky overflow flag for dropped captures.

---
 rtl/count_capture_pkg.sv | 13 +
 rtl/sync_fifo.sv | 53 +++++
 rtl/count_capture.sv | 101 ++++++++++
 tb/tb_count_capture.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_capture_pkg.sv
// Shared types and constants for the count_capture input-capture block.
package count_capture_pkg;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_sel_e;

    localparam int unsigned ARM_CYCLES = 3;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; a write into a full FIFO is
// accepted only when a read retires the head on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int LW = $clog2(DEPTH + 1);

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_wr;
    logic             do_rd;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd   = rd_en & ~empty;
    assign do_wr   = wr_en & (~full | do_rd);
    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign level   = LW'(wr_ptr - rd_ptr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_wr) begin
                mem[wr_ptr[AW-1:0]] <= wr_data;
                wr_ptr              <= wr_ptr + PW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

endmodule

// File: rtl/count_capture.sv
// Input capture: synchronises event_in, detects the selected edge and
// timestamps the upstream counter value into a FIFO with a sticky drop flag.
module count_capture
    import count_capture_pkg::*;
#(
    parameter int NUM_BITS = 8,
    parameter int DEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_BITS-1:0]        count,
    input  logic                       event_in,
    input  logic [1:0]                 edge_sel,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NUM_BITS-1:0]        out_data,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       overflow,
    input  logic                       clear_overflow
);

    localparam int ARM_W = $clog2(ARM_CYCLES + 1);

    logic             sync1;
    logic             sync2;
    logic             prev;
    logic [ARM_W-1:0] arm_cnt;
    logic             armed;
    logic             rise;
    logic             fall;
    logic             hit;
    logic             detect;
    logic             pop;
    logic             drop;
    logic             full;
    logic             empty;

    // Arming hides the 0->1 seen by the synchroniser when event_in is
    // already high as reset releases.
    assign armed = (arm_cnt == ARM_W'(ARM_CYCLES));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            prev    <= 1'b0;
            arm_cnt <= '0;
        end else begin
            sync1 <= event_in;
            sync2 <= sync1;
            prev  <= sync2;
            if (!armed) begin
                arm_cnt <= arm_cnt + ARM_W'(1);
            end
        end
    end

    assign rise = sync2 & ~prev;
    assign fall = ~sync2 & prev;

    always_comb begin
        hit = 1'b0;
        case (edge_sel_e'(edge_sel))
            EDGE_RISE: hit = rise;
            EDGE_FALL: hit = fall;
            EDGE_BOTH: hit = rise | fall;
            default:   hit = 1'b0;
        endcase
    end

    assign detect    = armed & hit;
    assign out_valid = ~empty;
    assign pop       = out_valid & out_ready;
    assign drop      = detect & full & ~pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clear_overflow) begin
            overflow <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (NUM_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (detect),
        .wr_data (count),
        .rd_en   (pop),
        .rd_data (out_data),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

endmodule

// File: tb/tb_count_capture.sv
// Directed bench for count_capture: a per-cycle vector table for edge
// selection plus hand-written sequences for fill, overflow and reset cases.
module tb_count_capture;

    logic       clk;
    logic       reset;
    logic [7:0] count;
    logic       event_in;
    logic [1:0] edge_sel;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] level;
    logic       overflow;
    logic       clear_overflow;

    logic       cnt_manual;
    logic [7:0] cnt_man_val;
    logic [7:0] cnt_auto;
    logic       cnt_en;
    logic       cnt_load;
    logic [7:0] cnt_load_val;

    int total;
    int bad;

    typedef struct {
        logic       ev;
        logic [1:0] sel;
        logic       rdy;
        logic [7:0] cnt;
        logic       exp_valid;
        logic [2:0] exp_level;
        logic       chk_data;
        logic [7:0] exp_data;
    } vec_t;

    vec_t tbl [14];

    count_capture #(.NUM_BITS(8), .DEPTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .count          (count),
        .event_in       (event_in),
        .edge_sel       (edge_sel),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .level          (level),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Upstream counter model: updates 1 time unit after each edge.
    always begin
        @(posedge clk);
        #1;
        if (cnt_load) cnt_auto = cnt_load_val;
        else if (cnt_en) cnt_auto = cnt_auto + 8'd1;
    end

    assign count = cnt_manual ? cnt_man_val : cnt_auto;

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic pulse_rise();
        event_in = 1'b1;
        repeat (3) cyc();
        event_in = 1'b0;
        repeat (3) cyc();
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b1;
        event_in = 1'b0;
        edge_sel = 2'b00;
        out_ready = 1'b0;
        clear_overflow = 1'b0;
        cnt_manual = 1'b0;
        cnt_man_val = 8'h00;
        cnt_auto = 8'h00;
        cnt_en = 1'b0;
        cnt_load = 1'b0;
        cnt_load_val = 8'h00;

        //          ev    sel    rdy   cnt    vld   lvl   chk   data
        tbl[0]  = '{1'b1, 2'b10, 1'b0, 8'h50, 1'b0, 3'd0, 1'b0, 8'h00};
        tbl[1]  = '{1'b1, 2'b10, 1'b0, 8'h51, 1'b0, 3'd0, 1'b0, 8'h00};
        tbl[2]  = '{1'b1, 2'b10, 1'b0, 8'h52, 1'b0, 3'd0, 1'b0, 8'h00};
        tbl[3]  = '{1'b0, 2'b10, 1'b0, 8'h53, 1'b0, 3'd0, 1'b0, 8'h00};
        tbl[4]  = '{1'b0, 2'b10, 1'b0, 8'h54, 1'b0, 3'd0, 1'b0, 8'h00};
        tbl[5]  = '{1'b0, 2'b10, 1'b0, 8'h55, 1'b1, 3'd1, 1'b1, 8'h55};
        tbl[6]  = '{1'b1, 2'b00, 1'b0, 8'h56, 1'b1, 3'd1, 1'b1, 8'h55};
        tbl[7]  = '{1'b1, 2'b00, 1'b0, 8'h57, 1'b1, 3'd1, 1'b1, 8'h55};
        tbl[8]  = '{1'b1, 2'b00, 1'b0, 8'h58, 1'b1, 3'd1, 1'b1, 8'h55};
        tbl[9]  = '{1'b0, 2'b11, 1'b0, 8'h59, 1'b1, 3'd1, 1'b1, 8'h55};
        tbl[10] = '{1'b0, 2'b11, 1'b0, 8'h5A, 1'b1, 3'd1, 1'b1, 8'h55};
        tbl[11] = '{1'b0, 2'b11, 1'b0, 8'h5B, 1'b1, 3'd2, 1'b1, 8'h55};
        tbl[12] = '{1'b0, 2'b01, 1'b1, 8'h5C, 1'b1, 3'd1, 1'b1, 8'h5B};
        tbl[13] = '{1'b0, 2'b01, 1'b1, 8'h5D, 1'b0, 3'd0, 1'b0, 8'h00};

        // Reset state
        repeat (3) cyc();
        chk("rst valid", out_valid, 0);
        chk("rst level", level, 0);
        chk("rst overflow", overflow, 0);
        chk("rst data", out_data, 0);
        reset = 1'b0;
        repeat (5) cyc();

        // Single rising edge, count 0x10 in the detect cycle
        edge_sel = 2'b01;
        cnt_en = 1'b1;
        cnt_load = 1'b1;
        cnt_load_val = 8'h0E;
        cyc();
        cnt_load = 1'b0;
        event_in = 1'b1;
        cyc();
        chk("t1 valid e1", out_valid, 0);
        cyc();
        chk("t1 valid e2", out_valid, 0);
        cyc();
        chk("t1 valid e3", out_valid, 1);
        chk("t1 data", out_data, 8'h10);
        chk("t1 level", level, 1);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        chk("t1 pop level", level, 0);
        chk("t1 pop valid", out_valid, 0);

        // Quiet falling edge, then table of per-cycle vectors
        edge_sel = 2'b00;
        event_in = 1'b0;
        repeat (4) cyc();
        chk("pre tbl level", level, 0);
        cnt_manual = 1'b1;
        for (int i = 0; i < 14; i++) begin
            event_in = tbl[i].ev;
            edge_sel = tbl[i].sel;
            out_ready = tbl[i].rdy;
            cnt_man_val = tbl[i].cnt;
            cyc();
            chk($sformatf("tbl%0d valid", i), out_valid, tbl[i].exp_valid);
            chk($sformatf("tbl%0d level", i), level, tbl[i].exp_level);
            chk($sformatf("tbl%0d overflow", i), overflow, 0);
            if (tbl[i].chk_data) chk($sformatf("tbl%0d data", i), out_data, tbl[i].exp_data);
        end
        out_ready = 1'b0;
        cnt_manual = 1'b0;

        // Both edges, fill to 4, fifth toggle drops, drain in order
        edge_sel = 2'b11;
        cnt_load = 1'b1;
        cnt_load_val = 8'h20;
        cyc();
        cnt_load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            event_in = ~event_in;
            repeat (5) cyc();
        end
        chk("t2 level full", level, 4);
        chk("t2 no overflow", overflow, 0);
        event_in = ~event_in;
        repeat (3) cyc();
        chk("t2 level after drop", level, 4);
        chk("t2 overflow", overflow, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2 drain%0d", i), out_data, 8'h22 + 8'(5 * i));
            cyc();
        end
        out_ready = 1'b0;
        chk("t2 drained level", level, 0);
        clear_overflow = 1'b1;
        cyc();
        clear_overflow = 1'b0;
        chk("t2 clear overflow", overflow, 0);

        // Full FIFO with pop on the same edge as a write
        cnt_load = 1'b1;
        cnt_load_val = 8'h60;
        cyc();
        cnt_load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            event_in = ~event_in;
            repeat (5) cyc();
        end
        chk("t3 level full", level, 4);
        event_in = ~event_in;
        repeat (2) cyc();
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        chk("t3 level", level, 4);
        chk("t3 overflow", overflow, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3 drain%0d", i), out_data, 8'h67 + 8'(5 * i));
            cyc();
        end
        out_ready = 1'b0;
        chk("t3 drained level", level, 0);

        // event_in high through reset: no spurious capture
        cnt_manual = 1'b1;
        cnt_man_val = 8'h33;
        edge_sel = 2'b01;
        event_in = 1'b1;
        reset = 1'b1;
        repeat (3) cyc();
        reset = 1'b0;
        repeat (6) cyc();
        chk("t4 no capture valid", out_valid, 0);
        chk("t4 no capture level", level, 0);
        event_in = 1'b0;
        repeat (4) cyc();
        chk("t4 fall ignored", level, 0);
        event_in = 1'b1;
        repeat (3) cyc();
        chk("t4 one capture", level, 1);
        chk("t4 data", out_data, 8'h33);
        repeat (3) cyc();
        chk("t4 still one", level, 1);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        event_in = 1'b0;
        repeat (3) cyc();

        // Set beats clear on a simultaneous drop
        cnt_man_val = 8'h44;
        for (int i = 0; i < 5; i++) pulse_rise();
        chk("t5 level", level, 4);
        chk("t5 overflow set", overflow, 1);
        event_in = 1'b1;
        repeat (2) cyc();
        clear_overflow = 1'b1;
        cyc();
        clear_overflow = 1'b0;
        chk("t5 set wins", overflow, 1);
        chk("t5 level kept", level, 4);
        event_in = 1'b0;
        cyc();
        clear_overflow = 1'b1;
        cyc();
        clear_overflow = 1'b0;
        chk("t5 clear alone", overflow, 0);

        // Paused counter, then reset mid-drain
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        repeat (5) cyc();
        cnt_man_val = 8'h2A;
        pulse_rise();
        pulse_rise();
        chk("t6 level two", level, 2);
        chk("t6 data first", out_data, 8'h2A);
        for (int i = 0; i < 3; i++) pulse_rise();
        chk("t6 level full", level, 4);
        chk("t6 overflow", overflow, 1);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        chk("t6 level after pop", level, 3);
        chk("t6 data second", out_data, 8'h2A);
        reset = 1'b1;
        #1;
        chk("t6 reset level", level, 0);
        chk("t6 reset valid", out_valid, 0);
        chk("t6 reset overflow", overflow, 0);
        cyc();
        reset = 1'b0;
        repeat (2) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
